// File: rtl/add_mult_acc_pipe.sv
// add_mult_acc_pipe: stallable pre-add / signed multiply / accumulate pipeline.
// Each beat forms two signed pre-adds and multiplies them; ACC_LEN products are
// summed into one result delivered over a valid/ready output port.
// Optional feature macro: ADD_MULT_ACC_SAT_EN (saturating accumulation).
// Without it the accumulator wraps and ovf_o flags signed wrap in the group.
module add_mult_acc_pipe #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int ACC_SIZE  = 32,
  parameter int ACC_LEN   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [IN_SIZE_0-1:0] in_0_i [0:1],
  input  logic signed [IN_SIZE_1-1:0] in_1_i [0:1],
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic signed [ACC_SIZE-1:0]  out_o,
  output logic                        ovf_o
);

  localparam int SUM_W  = IN_SIZE_1 + 1;
  localparam int PROD_W = 2 * SUM_W;
  localparam int CNT_W  = $clog2(ACC_LEN + 1);
  localparam int EXT_W  = (ACC_SIZE > PROD_W) ? (ACC_SIZE - PROD_W) : 1;

  localparam logic [CNT_W-1:0]          LAST_CNT = CNT_W'(ACC_LEN - 1);
  localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

  logic adv;
  logic accept;

  logic s1Valid_q, s2Valid_q;
  logic s3Valid_q, s3Valid_d;
  logic outValid_q, outValid_d;

  logic signed [SUM_W-1:0] ext00, ext01, ext10, ext11;
  logic signed [SUM_W-1:0] sum0_q, sum0_d, sum1_q, sum1_d;

  logic signed [PROD_W-1:0] mulA, mulB;
  logic signed [PROD_W-1:0] prod_q, prod_d;

  logic signed [ACC_SIZE-1:0] prodExt, accBase, rawSum, accStep;
  logic                       stepOvf, grpOvf;

  logic signed [ACC_SIZE-1:0] acc_q, acc_d;
  logic signed [ACC_SIZE-1:0] s3Acc_q, s3Acc_d;
  logic signed [ACC_SIZE-1:0] out_q, out_d;
  logic                       ovfAcc_q, ovfAcc_d;
  logic                       s3Ovf_q, s3Ovf_d;
  logic                       ovfOut_q, ovfOut_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  // The whole pipeline moves only when the output register is free or being drained.
  assign adv     = !outValid_q || out_ready_i;
  assign ready_o = adv && !clear_i && !rst_i;
  assign accept  = valid_i && ready_o;

  // Operands are sign-extended to the pre-add width so the sums are exact.
  assign ext00  = {{(SUM_W-IN_SIZE_0){in_0_i[0][IN_SIZE_0-1]}}, in_0_i[0]};
  assign ext01  = {{(SUM_W-IN_SIZE_0){in_0_i[1][IN_SIZE_0-1]}}, in_0_i[1]};
  assign ext10  = {{(SUM_W-IN_SIZE_1){in_1_i[0][IN_SIZE_1-1]}}, in_1_i[0]};
  assign ext11  = {{(SUM_W-IN_SIZE_1){in_1_i[1][IN_SIZE_1-1]}}, in_1_i[1]};
  assign sum0_d = ext01 + ext10;
  assign sum1_d = ext00 + ext11;

  // Full-width operands make the product exact in PROD_W bits.
  assign mulA   = {{SUM_W{sum0_q[SUM_W-1]}}, sum0_q};
  assign mulB   = {{SUM_W{sum1_q[SUM_W-1]}}, sum1_q};
  assign prod_d = mulA * mulB;

  // Bring the product into the accumulator domain; a narrower accumulator keeps the low bits.
  generate
    if (ACC_SIZE > PROD_W) begin : gProdExtend
      assign prodExt = {{EXT_W{prod_q[PROD_W-1]}}, prod_q};
    end else begin : gProdTrunc
      assign prodExt = prod_q[ACC_SIZE-1:0];
    end
  endgenerate

  // One accumulate step: a zero count starts a fresh group, overflow is judged on sign bits.
  always_comb begin
    accBase = (cnt_q == '0) ? '0 : acc_q;
    rawSum  = accBase + prodExt;
    stepOvf = (accBase[ACC_SIZE-1] == prodExt[ACC_SIZE-1]) &&
              (rawSum[ACC_SIZE-1] != accBase[ACC_SIZE-1]);
`ifdef ADD_MULT_ACC_SAT_EN
    accStep = stepOvf ? (accBase[ACC_SIZE-1] ? ACC_MIN : ACC_MAX) : rawSum;
`else
    accStep = rawSum;
`endif
    grpOvf  = stepOvf || ((cnt_q != '0) && ovfAcc_q);
  end

  // Next state for the accumulator, group counter, completion stage and output register.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ovfAcc_d   = ovfAcc_q;
    s3Valid_d  = s3Valid_q;
    s3Acc_d    = s3Acc_q;
    s3Ovf_d    = s3Ovf_q;
    outValid_d = outValid_q;
    out_d      = out_q;
    ovfOut_d   = ovfOut_q;
    if (clear_i) begin
      cnt_d      = '0;
      s3Valid_d  = 1'b0;
      outValid_d = 1'b0;
    end else if (adv) begin
      s3Valid_d = 1'b0;
      if (s2Valid_q) begin
        acc_d    = accStep;
        ovfAcc_d = grpOvf;
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          s3Valid_d = 1'b1;
          s3Acc_d   = accStep;
          s3Ovf_d   = grpOvf;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      outValid_d = s3Valid_q;
      if (s3Valid_q) begin
        out_d    = s3Acc_q;
        ovfOut_d = s3Ovf_q;
      end
    end
  end

  // Pre-add and multiply stages; clear drops in-flight beats, a stall freezes them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      sum0_q    <= '0;
      sum1_q    <= '0;
      prod_q    <= '0;
    end else if (clear_i) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
    end else if (adv) begin
      s1Valid_q <= accept;
      s2Valid_q <= s1Valid_q;
      sum0_q    <= sum0_d;
      sum1_q    <= sum1_d;
      prod_q    <= prod_d;
    end
  end

  // Accumulator, counter, completion stage and held output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      ovfAcc_q   <= 1'b0;
      s3Valid_q  <= 1'b0;
      s3Acc_q    <= '0;
      s3Ovf_q    <= 1'b0;
      outValid_q <= 1'b0;
      out_q      <= '0;
      ovfOut_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovfAcc_q   <= ovfAcc_d;
      s3Valid_q  <= s3Valid_d;
      s3Acc_q    <= s3Acc_d;
      s3Ovf_q    <= s3Ovf_d;
      outValid_q <= outValid_d;
      out_q      <= out_d;
      ovfOut_q   <= ovfOut_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_o       = out_q;
  assign ovf_o       = ovfOut_q;

endmodule

// File: tb/tb_add_mult_acc_pipe.sv
// tb_add_mult_acc_pipe: directed vectors for add_mult_acc_pipe.
// Two instances with ACC_LEN=4 share stimulus: a 32-bit accumulator and a 16-bit
// one that exercises wrap/saturation (ADD_MULT_ACC_SAT_EN selects the expectation).
module tb_add_mult_acc_pipe;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_i, clear_i, valid_i, out_ready_i;
  logic signed [3:0] in0 [0:1];
  logic signed [7:0] in1 [0:1];

  logic               readyA, outValidA, ovfA;
  logic signed [31:0] outA;
  logic               readyB, outValidB, ovfB;
  logic signed [15:0] outB;

  int   checks = 0;
  int   errors = 0;
  logic accepted;
  logic taken;

  typedef struct {
    logic signed [3:0]  a0, a1;
    logic signed [7:0]  b0, b1;
    logic signed [63:0] exp32;
    logic signed [63:0] exp16;
    logic               ovf16;
  } vec_t;

  vec_t vecs [5];

  add_mult_acc_pipe #(.IN_SIZE_0(4), .IN_SIZE_1(8), .ACC_SIZE(32), .ACC_LEN(4)) dutA (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i), .ready_o(readyA),
    .in_0_i(in0), .in_1_i(in1), .out_valid_o(outValidA), .out_ready_i(out_ready_i),
    .out_o(outA), .ovf_o(ovfA)
  );

  add_mult_acc_pipe #(.IN_SIZE_0(4), .IN_SIZE_1(8), .ACC_SIZE(16), .ACC_LEN(4)) dutB (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i), .ready_o(readyB),
    .in_0_i(in0), .in_1_i(in1), .out_valid_o(outValidB), .out_ready_i(out_ready_i),
    .out_o(outB), .ovf_o(ovfB)
  );

  function automatic vec_t mkVec(input int a0, input int a1, input int b0, input int b1,
                                 input longint e32, input longint e16, input bit o16);
    vec_t v;
    v.a0    = 4'(a0);
    v.a1    = 4'(a1);
    v.b0    = 8'(b0);
    v.b1    = 8'(b1);
    v.exp32 = e32;
    v.exp16 = e16;
    v.ovf16 = o16;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, sample at the falling edge.
  task automatic applyStimulus(input logic v, input vec_t d, input logic oRdy,
                               input logic clr, input logic rst);
    @(posedge clk_i);
    #1;
    valid_i     = v;
    in0[0]      = d.a0;
    in0[1]      = d.a1;
    in1[0]      = d.b0;
    in1[1]      = d.b1;
    out_ready_i = oRdy;
    clear_i     = clr;
    rst_i       = rst;
    @(negedge clk_i);
    accepted = valid_i && readyA;
    taken    = outValidA && out_ready_i;
  endtask

  // Four beats of one vector, optional idle gaps, then latency and value checks.
  task automatic runGroup(input vec_t v, input bit gaps, input string tag);
    int sent  = 0;
    int guard = 0;
    int lat   = 0;
    bit on    = 1'b1;
    bit found = 1'b0;
    while (sent < 4 && guard < 40) begin
      applyStimulus(on, v, 1'b1, 1'b0, 1'b0);
      if (accepted) sent++;
      if (gaps) on = !on;
      guard++;
    end
    checkOutput({tag, " beats accepted"}, sent, 4);
    while (!found && lat < 10) begin
      applyStimulus(1'b0, v, 1'b1, 1'b0, 1'b0);
      lat++;
      if (outValidA) found = 1'b1;
    end
    checkOutput({tag, " latency"}, lat - 1, 3);
    checkOutput({tag, " out_o acc32"}, outA, v.exp32);
    checkOutput({tag, " ovf_o acc32"}, ovfA, 0);
    checkOutput({tag, " out_o acc16"}, outB, v.exp16);
    checkOutput({tag, " ovf_o acc16"}, ovfB, v.ovf16);
    applyStimulus(1'b0, v, 1'b1, 1'b0, 1'b0);
    checkOutput({tag, " out_valid_o drop"}, outValidA, 0);
  endtask

  // Feed beats with the output stalled until a result is held.
  task automatic fillAndHold(input vec_t v, input int nBeats);
    int sent  = 0;
    int guard = 0;
    while (!outValidA && guard < 30) begin
      applyStimulus(sent < nBeats, v, 1'b0, 1'b0, 1'b0);
      if (accepted) sent++;
      guard++;
    end
    checkOutput("held result present", outValidA, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t         cur;
    int           sent;
    int           nres;
    int           guard;
    logic signed [31:0] res [2];

    vecs[0] = mkVec(1, 2, 3, 4, 100, 100, 1'b0);
`ifdef ADD_MULT_ACC_SAT_EN
    vecs[1] = mkVec(-8, -8, -128, -128, 73984, 32767, 1'b1);
    vecs[2] = mkVec(7, -8, 127, -128, -57596, -32768, 1'b1);
`else
    vecs[1] = mkVec(-8, -8, -128, -128, 73984, 8448, 1'b1);
    vecs[2] = mkVec(7, -8, 127, -128, -57596, 7940, 1'b1);
`endif
    vecs[3] = mkVec(0, 0, 0, 0, 0, 0, 1'b0);
    vecs[4] = mkVec(-1, 3, 5, -2, -96, -96, 1'b0);

    rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0; out_ready_i = 1'b1;
    in0[0] = '0; in0[1] = '0; in1[0] = '0; in1[1] = '0;
    repeat (2) @(posedge clk_i);

    applyStimulus(1'b1, vecs[0], 1'b1, 1'b0, 1'b1);
    checkOutput("reset ready_o", readyA, 0);
    checkOutput("reset out_valid_o", outValidA, 0);
    checkOutput("reset out_o", outA, 0);
    checkOutput("reset ovf_o", ovfA, 0);
    applyStimulus(1'b0, vecs[0], 1'b1, 1'b0, 1'b0);
    checkOutput("ready_o after reset", readyA, 1);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d back-to-back", i);
      runGroup(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end
    runGroup(vecs[4], 1'b1, "gap vec4");
    runGroup(vecs[2], 1'b1, "gap vec2");

    $display("[TB] backpressure with two groups");
    sent  = 0;
    guard = 0;
    while (!outValidA && guard < 30) begin
      cur = (sent < 4) ? vecs[0] : vecs[4];
      applyStimulus(sent < 8, cur, 1'b0, 1'b0, 1'b0);
      if (accepted) sent++;
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      cur = (sent < 4) ? vecs[0] : vecs[4];
      applyStimulus(sent < 8, cur, 1'b0, 1'b0, 1'b0);
      if (accepted) sent++;
      checkOutput("stall ready_o", readyA, 0);
      checkOutput("stall out_valid_o", outValidA, 1);
      checkOutput("stall out_o", outA, 100);
    end
    nres  = 0;
    guard = 0;
    while (nres < 2 && guard < 30) begin
      cur = (sent < 4) ? vecs[0] : vecs[4];
      applyStimulus(sent < 8, cur, 1'b1, 1'b0, 1'b0);
      if (accepted) sent++;
      if (taken) begin
        res[nres] = outA;
        nres++;
      end
      guard++;
    end
    checkOutput("backpressure results", nres, 2);
    checkOutput("backpressure first", res[0], 100);
    checkOutput("backpressure second", res[1], -96);
    checkOutput("backpressure beats", sent, 8);
    applyStimulus(1'b0, vecs[0], 1'b1, 1'b0, 1'b0);
    checkOutput("backpressure no extra", outValidA, 0);

    $display("[TB] clear mid-group");
    applyStimulus(1'b1, vecs[1], 1'b1, 1'b0, 1'b0);
    checkOutput("partial beat 0", accepted, 1);
    applyStimulus(1'b1, vecs[1], 1'b1, 1'b0, 1'b0);
    checkOutput("partial beat 1", accepted, 1);
    applyStimulus(1'b1, vecs[1], 1'b1, 1'b1, 1'b0);
    checkOutput("clear ready_o", readyA, 0);
    runGroup(vecs[0], 1'b0, "after clear");

    $display("[TB] clear drops held output");
    fillAndHold(vecs[0], 4);
    applyStimulus(1'b0, vecs[0], 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, vecs[0], 1'b0, 1'b0, 1'b0);
    checkOutput("clear drops out_valid_o", outValidA, 0);

    $display("[TB] reset mid-operation");
    fillAndHold(vecs[1], 6);
    checkOutput("held out_o", outA, 73984);
    applyStimulus(1'b1, vecs[1], 1'b0, 1'b0, 1'b1);
    checkOutput("mid reset ready_o", readyA, 0);
    applyStimulus(1'b1, vecs[1], 1'b0, 1'b0, 1'b1);
    checkOutput("mid reset out_valid_o", outValidA, 0);
    checkOutput("mid reset out_o", outA, 0);
    checkOutput("mid reset ovf_o acc16", ovfB, 0);
    checkOutput("mid reset out_o acc16", outB, 0);
    runGroup(vecs[0], 1'b0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
